vc_arbiter_ctrl: RTL and testbench

Controller/arbiter that drains the VC0 and VC1 virtual-channel FIFOs into a single downstream datapath feeding destination FIFOs D0/D1. It owns the block's configuration sequence: it latches FIFO thresholds during init and distributes them to the FIFOs. It then performs round-robin arbitration between the two VCs, routes each word to D0 or D1 by a header bit, and applies back-pressure from the destination FIFOs. It reports block status as IDLE or ACTIVE.

---
 rtl/vc_arbiter_ctrl.sv | 168 ++++++++++++++++
 tb/tb_vc_arbiter_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter_ctrl.sv
// Round-robin arbiter draining VC0/VC1 into D0/D1 with threshold configuration,
// destination routing by header bit and back-pressure from the destination FIFOs.
module vc_arbiter_ctrl #(
    parameter int unsigned data_width   = 6,
    parameter int unsigned umbral_width = 4,
    parameter int unsigned dest_bit     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [umbral_width-1:0] Umbral_VC0_in,
    input  logic [umbral_width-1:0] Umbral_VC1_in,
    input  logic [umbral_width-1:0] Umbral_D0_in,
    input  logic [umbral_width-1:0] Umbral_D1_in,
    input  logic                    empty_fifo_VC0,
    input  logic                    empty_fifo_VC1,
    input  logic [data_width-1:0]   data_out_VC0,
    input  logic [data_width-1:0]   data_out_VC1,
    input  logic                    almost_full_D0,
    input  logic                    full_D0,
    input  logic                    almost_full_D1,
    input  logic                    full_D1,
    output logic                    pop_VC0_fifo,
    output logic                    pop_VC1_fifo,
    output logic                    push_D0,
    output logic                    push_D1,
    output logic [data_width-1:0]   data_out,
    output logic [umbral_width-1:0] Umbral_VC0,
    output logic [umbral_width-1:0] Umbral_VC1,
    output logic [umbral_width-1:0] Umbral_D0,
    output logic [umbral_width-1:0] Umbral_D1,
    output logic [2:0]              state,
    output logic                    active_out,
    output logic                    idle_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3
    } state_t;

    state_t                  r_state;
    logic                    r_active;
    logic                    r_idle;
    logic [umbral_width-1:0] r_umb_vc0;
    logic [umbral_width-1:0] r_umb_vc1;
    logic [umbral_width-1:0] r_umb_d0;
    logic [umbral_width-1:0] r_umb_d1;
    logic                    r_last_vc1;
    logic                    r_s1_vld;
    logic                    r_s1_src;
    logic                    r_push_d0;
    logic                    r_push_d1;
    logic [data_width-1:0]   r_data;

    logic                    w_pause;
    logic                    w_arb_en;
    logic                    w_req0;
    logic                    w_req1;
    logic                    w_grant0;
    logic                    w_grant1;
    logic                    w_pipe_empty;
    logic [data_width-1:0]   w_rd_data;

    // Grant the requester that did not win last when both VCs have data
    assign w_pause      = almost_full_D0 | full_D0 | almost_full_D1 | full_D1;
    assign w_arb_en     = (r_state == ST_ACTIVE) & ~init & ~w_pause;
    assign w_req0       = ~empty_fifo_VC0;
    assign w_req1       = ~empty_fifo_VC1;
    assign w_grant0     = w_arb_en & w_req0 & (~w_req1 | r_last_vc1);
    assign w_grant1     = w_arb_en & w_req1 & (~w_req0 | ~r_last_vc1);
    assign w_pipe_empty = ~r_s1_vld & ~r_push_d0 & ~r_push_d1;
    assign w_rd_data    = r_s1_src ? data_out_VC1 : data_out_VC0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RESET;
            r_active  <= 1'b0;
            r_idle    <= 1'b0;
            r_umb_vc0 <= '0;
            r_umb_vc1 <= '0;
            r_umb_d0  <= '0;
            r_umb_d1  <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_INIT;
                end
                ST_INIT: begin
                    r_umb_vc0 <= Umbral_VC0_in;
                    r_umb_vc1 <= Umbral_VC1_in;
                    r_umb_d0  <= Umbral_D0_in;
                    r_umb_d1  <= Umbral_D1_in;
                    if (!init) begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        r_state <= ST_INIT;
                        r_idle  <= 1'b0;
                    end else if (w_req0 || w_req1) begin
                        r_state  <= ST_ACTIVE;
                        r_idle   <= 1'b0;
                        r_active <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (init) begin
                        r_state  <= ST_INIT;
                        r_active <= 1'b0;
                    end else if (!w_req0 && !w_req1 && w_pipe_empty) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_idle   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_RESET;
                    r_active <= 1'b0;
                    r_idle   <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage read pipeline: pop -> source tag -> routed push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_vc1 <= 1'b1;
            r_s1_vld   <= 1'b0;
            r_s1_src   <= 1'b0;
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_data     <= '0;
        end else begin
            r_s1_vld  <= w_grant0 | w_grant1;
            r_s1_src  <= w_grant1;
            r_push_d0 <= r_s1_vld & ~w_rd_data[dest_bit];
            r_push_d1 <= r_s1_vld & w_rd_data[dest_bit];
            if (w_grant0) begin
                r_last_vc1 <= 1'b0;
            end else if (w_grant1) begin
                r_last_vc1 <= 1'b1;
            end
            if (r_s1_vld) begin
                r_data <= w_rd_data;
            end
        end
    end

    assign pop_VC0_fifo = w_grant0;
    assign pop_VC1_fifo = w_grant1;
    assign push_D0      = r_push_d0;
    assign push_D1      = r_push_d1;
    assign data_out     = r_data;
    assign Umbral_VC0   = r_umb_vc0;
    assign Umbral_VC1   = r_umb_vc1;
    assign Umbral_D0    = r_umb_d0;
    assign Umbral_D1    = r_umb_d1;
    assign state        = r_state;
    assign active_out   = r_active;
    assign idle_out     = r_idle;

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
// Directed bench for vc_arbiter_ctrl with behavioural VC FIFOs and a pop/push event log.
module tb_vc_arbiter_ctrl;

    localparam int unsigned DW = 6;
    localparam int unsigned UW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [UW-1:0] u_vc0_in, u_vc1_in, u_d0_in, u_d1_in;
    logic          e0, e1;
    logic [DW-1:0] d_vc0 = '0;
    logic [DW-1:0] d_vc1 = '0;
    logic          af0, f0, af1, f1;
    logic          pop0, pop1, push0, push1;
    logic [DW-1:0] data_out;
    logic [UW-1:0] u_vc0, u_vc1, u_d0, u_d1;
    logic [2:0]    state;
    logic          active_out, idle_out;

    vc_arbiter_ctrl #(.data_width(DW), .umbral_width(UW), .dest_bit(4)) dut (
        .clk(clk), .reset(reset), .init(init),
        .Umbral_VC0_in(u_vc0_in), .Umbral_VC1_in(u_vc1_in),
        .Umbral_D0_in(u_d0_in), .Umbral_D1_in(u_d1_in),
        .empty_fifo_VC0(e0), .empty_fifo_VC1(e1),
        .data_out_VC0(d_vc0), .data_out_VC1(d_vc1),
        .almost_full_D0(af0), .full_D0(f0), .almost_full_D1(af1), .full_D1(f1),
        .pop_VC0_fifo(pop0), .pop_VC1_fifo(pop1), .push_D0(push0), .push_D1(push1),
        .data_out(data_out),
        .Umbral_VC0(u_vc0), .Umbral_VC1(u_vc1), .Umbral_D0(u_d0), .Umbral_D1(u_d1),
        .state(state), .active_out(active_out), .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // VC FIFO models: registered read data, empty updates on the popping edge
    logic [DW-1:0] mem0 [64];
    logic [DW-1:0] mem1 [64];
    logic [5:0]    tail0 = '0, tail1 = '0, head0 = '0, head1 = '0;
    assign e0 = (head0 == tail0);
    assign e1 = (head1 == tail1);

    always @(posedge clk) begin
        if (pop0) begin
            d_vc0 <= mem0[head0];
            head0 <= head0 + 6'd1;
        end
        if (pop1) begin
            d_vc1 <= mem1[head1];
            head1 <= head1 + 6'd1;
        end
    end

    // Event log of pops and pushes, sampled mid-cycle
    int            pop_cyc[$];
    int            pop_vc[$];
    int            push_cyc[$];
    int            push_dst[$];
    logic [DW-1:0] push_dat[$];
    int            both_pop = 0;
    int            both_push = 0;

    always @(negedge clk) begin
        if (pop0) begin pop_cyc.push_back(cyc); pop_vc.push_back(0); end
        if (pop1) begin pop_cyc.push_back(cyc); pop_vc.push_back(1); end
        if (pop0 && pop1) both_pop = both_pop + 1;
        if (push0) begin push_cyc.push_back(cyc); push_dst.push_back(0); push_dat.push_back(data_out); end
        if (push1) begin push_cyc.push_back(cyc); push_dst.push_back(1); push_dat.push_back(data_out); end
        if (push0 && push1) both_push = both_push + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load0(input logic [DW-1:0] w);
        mem0[tail0] = w;
        tail0 = tail0 + 6'd1;
    endtask

    task automatic load1(input logic [DW-1:0] w);
        mem1[tail1] = w;
        tail1 = tail1 + 6'd1;
    endtask

    task automatic wait_pushes(input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (push_cyc.size() >= target) break;
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_pops(input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (pop_cyc.size() >= target) break;
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (idle_out) break;
            @(negedge clk); #1;
        end
    endtask

    logic [DW-1:0] rr_dat [6];
    int            rr_dst [6];
    logic [DW-1:0] sv_dat [4];
    int            sv_dst [4];
    logic [DW-1:0] bp_dat [6];
    logic [DW-1:0] im_dat [5];
    int            lc, bp, bpu, np, nq, p2, q1;

    initial begin
        reset = 1'b0; init = 1'b0;
        u_vc0_in = '0; u_vc1_in = '0; u_d0_in = '0; u_d1_in = '0;
        af0 = 1'b0; f0 = 1'b0; af1 = 1'b0; f1 = 1'b0;
        rr_dat = '{6'h02, 6'h21, 6'h13, 6'h15, 6'h04, 6'h06};
        rr_dst = '{0, 0, 1, 1, 0, 0};
        sv_dat = '{6'h00, 6'h10, 6'h01, 6'h11};
        sv_dst = '{0, 1, 0, 1};
        bp_dat = '{6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A};
        im_dat = '{6'h15, 6'h16, 6'h17, 6'h18, 6'h19};

        // Reset and threshold load
        tick(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'({pop0, pop1, push0, push1, data_out, u_vc0, u_vc1, u_d0, u_d1,
                             active_out, idle_out}), 32'd0);
        init = 1'b1; u_vc0_in = 4'd3; u_vc1_in = 4'd5; u_d0_in = 4'd6; u_d1_in = 4'd7;
        reset = 1'b1;
        tick(1);
        chk("init_state", 32'(state), 32'd1);
        tick(1);
        init = 1'b0;
        tick(1);
        chk("idle_state", 32'(state), 32'd2);
        chk("idle_flags", 32'({active_out, idle_out}), 32'b01);
        chk("umb_load", 32'({u_vc0, u_vc1, u_d0, u_d1}), 32'h3567);
        u_vc0_in = '0; u_vc1_in = '0; u_d0_in = '0; u_d1_in = '0;
        tick(3);
        chk("umb_hold", 32'({u_vc0, u_vc1, u_d0, u_d1}), 32'h3567);

        // Round-robin with both VCs loaded
        lc = cyc; bp = pop_cyc.size(); bpu = push_cyc.size();
        load0(6'h02); load0(6'h13); load0(6'h04);
        load1(6'h21); load1(6'h15); load1(6'h06);
        tick(1);
        chk("rr_active", 32'({active_out, idle_out}), 32'b10);
        wait_pushes(bpu + 6, 30);
        chk("rr_npop", 32'(pop_cyc.size() - bp), 32'd6);
        chk("rr_npush", 32'(push_cyc.size() - bpu), 32'd6);
        if (pop_cyc.size() == bp + 6 && push_cyc.size() == bpu + 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("rr_popvc%0d", i), 32'(pop_vc[bp+i]), 32'(i % 2));
                chk($sformatf("rr_popcyc%0d", i), 32'(pop_cyc[bp+i]), 32'(lc + 1 + i));
                chk($sformatf("rr_pushcyc%0d", i), 32'(push_cyc[bpu+i]), 32'(lc + 3 + i));
                chk($sformatf("rr_dat%0d", i), 32'(push_dat[bpu+i]), 32'(rr_dat[i]));
                chk($sformatf("rr_dst%0d", i), 32'(push_dst[bpu+i]), 32'(rr_dst[i]));
            end
        end
        wait_idle(20);
        chk("rr_idle", 32'(state), 32'd2);
        tick(2);
        chk("rr_hold", 32'(data_out), 32'h06);

        // Single VC, destination routing on bit 4
        lc = cyc; bp = pop_cyc.size(); bpu = push_cyc.size();
        load0(6'h00); load0(6'h10); load0(6'h01); load0(6'h11);
        wait_pushes(bpu + 4, 30);
        chk("sv_npop", 32'(pop_cyc.size() - bp), 32'd4);
        chk("sv_npush", 32'(push_cyc.size() - bpu), 32'd4);
        if (pop_cyc.size() == bp + 4 && push_cyc.size() == bpu + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sv_popvc%0d", i), 32'(pop_vc[bp+i]), 32'd0);
                chk($sformatf("sv_popcyc%0d", i), 32'(pop_cyc[bp+i]), 32'(lc + 1 + i));
                chk($sformatf("sv_lat%0d", i), 32'(push_cyc[bpu+i] - pop_cyc[bp+i]), 32'd2);
                chk($sformatf("sv_dat%0d", i), 32'(push_dat[bpu+i]), 32'(sv_dat[i]));
                chk($sformatf("sv_dst%0d", i), 32'(push_dst[bpu+i]), 32'(sv_dst[i]));
            end
        end
        wait_idle(20);
        chk("sv_idle", 32'({active_out, idle_out}), 32'b01);

        // Back-pressure from D1 almost-full mid-stream
        bp = pop_cyc.size(); bpu = push_cyc.size();
        for (int i = 0; i < 6; i++) load0(bp_dat[i]);
        wait_pops(bp + 2, 10);
        chk("bp_start", 32'(pop_cyc.size() - bp), 32'd2);
        p2 = pop_cyc[pop_cyc.size() - 1];
        @(posedge clk); #1; af1 = 1'b1;
        tick(4);
        af1 = 1'b0;
        wait_pushes(bpu + 6, 30);
        np = 0; nq = 0;
        foreach (pop_cyc[i]) if (pop_cyc[i] >= p2 + 1 && pop_cyc[i] <= p2 + 4) np++;
        foreach (push_cyc[i]) if (push_cyc[i] >= p2 + 1 && push_cyc[i] <= p2 + 4) nq++;
        chk("bp_no_pop", 32'(np), 32'd0);
        chk("bp_inflight", 32'(nq), 32'd2);
        chk("bp_npush", 32'(push_cyc.size() - bpu), 32'd6);
        if (pop_cyc.size() == bp + 6 && push_cyc.size() == bpu + 6) begin
            chk("bp_resume", 32'(pop_cyc[bp+2]), 32'(p2 + 5));
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("bp_dat%0d", i), 32'(push_dat[bpu+i]), 32'(bp_dat[i]));
                chk($sformatf("bp_dst%0d", i), 32'(push_dst[bpu+i]), 32'd0);
            end
        end
        wait_idle(20);

        // Init request while active
        bp = pop_cyc.size(); bpu = push_cyc.size();
        for (int i = 0; i < 5; i++) load1(im_dat[i]);
        wait_pops(bp + 1, 10);
        q1 = pop_cyc[pop_cyc.size() - 1];
        @(posedge clk); #1;
        init = 1'b1; u_vc0_in = 4'h9; u_vc1_in = 4'hA; u_d0_in = 4'hB; u_d1_in = 4'hC;
        tick(1);
        chk("im_state", 32'(state), 32'd1);
        chk("im_cyc", 32'(cyc), 32'(q1 + 2));
        tick(2);
        chk("im_umb", 32'({u_vc0, u_vc1, u_d0, u_d1}), 32'h9ABC);
        chk("im_nopop", 32'(pop_cyc.size() - bp), 32'd1);
        chk("im_inflight", 32'(push_cyc.size() - bpu), 32'd1);
        init = 1'b0;
        wait_pushes(bpu + 5, 40);
        chk("im_npush", 32'(push_cyc.size() - bpu), 32'd5);
        if (push_cyc.size() == bpu + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("im_dat%0d", i), 32'(push_dat[bpu+i]), 32'(im_dat[i]));
                chk($sformatf("im_dst%0d", i), 32'(push_dst[bpu+i]), 32'd1);
            end
        end
        wait_idle(20);
        chk("im_idle", 32'(state), 32'd2);

        // Asynchronous reset between a pop and its push
        bp = pop_cyc.size(); bpu = push_cyc.size();
        load0(6'h1F); load0(6'h00);
        wait_pops(bp + 1, 10);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("ar_outs", 32'({pop0, pop1, push0, push1, data_out, u_vc0, u_vc1, u_d0, u_d1,
                           active_out, idle_out}), 32'd0);
        chk("ar_state", 32'(state), 32'd0);
        tick(3);
        chk("ar_nopush", 32'(push_cyc.size() - bpu), 32'd0);

        chk("no_dual_pop", 32'(both_pop), 32'd0);
        chk("no_dual_push", 32'(both_push), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
